cmd_arbiter: RTL and testbench

//  Shares the single cmd_proc command/response channel between two requesters:
//  - UART commands, buffered in a FIFO.
//  - Tour-sequencer commands, the 16-bit {opcode,heading,squares} moves.

---
 rtl/cmd_arbiter.sv | 133 +++++++++++++
 tb/tb_cmd_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter.sv
// Two-way owner arbiter for the cmd_proc channel: a buffered UART stream and the tour sequencer.
// Optional EXEC watchdog compiled in with `define ARB_TIMEOUT_EN (limit TIMEOUT_CYC cycles).
module cmd_arbiter #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 2**24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] uart_cmd,
  input  logic        uart_cmd_rdy,
  output logic        uart_clr,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  output logic        tour_clr,
  input  logic        tour_lock,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        uart_resp,
  output logic        tour_resp,
  output logic        owner,
  output logic        busy,
  output logic        fifo_full,
  output logic        timeout_err
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("cmd_arbiter: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {IDLE, GRANT, EXEC} state_t;

  state_t        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, uart_pend;
  logic          gnt_uart, gnt_tour;
  logic          rr_last;
  logic          tmo_hit;

  // Full is judged on the registered count only, so a pop never frees a slot in the same cycle.
  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign uart_pend = (count != '0);
  assign push      = uart_cmd_rdy && !fifo_full && !rst;
  assign pop       = gnt_uart;
  assign uart_clr  = push;
  assign tour_clr  = (state == GRANT) && clr_cmd_rdy && owner && !rst;
  assign busy      = (state != IDLE);

  always_comb begin
    gnt_uart = 1'b0;
    gnt_tour = 1'b0;
    if (state == IDLE) begin
      if (tour_lock) begin
        gnt_tour = tour_cmd_rdy;
      end else if (uart_pend && tour_cmd_rdy) begin
        // rr_last=1 means the tour had the last turn, so UART goes next
        gnt_uart = rr_last;
        gnt_tour = !rr_last;
      end else begin
        gnt_uart = uart_pend;
        gnt_tour = tour_cmd_rdy;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_uart || gnt_tour) state_nxt = GRANT;
      GRANT:   if (clr_cmd_rdy)          state_nxt = EXEC;
      EXEC:    if (send_resp || tmo_hit) state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= uart_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= 16'h0000;
      cmd_rdy   <= 1'b0;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      uart_resp <= 1'b0;
      tour_resp <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      uart_resp <= (state == EXEC) && send_resp && !owner;
      tour_resp <= (state == EXEC) && send_resp && owner;
      if (gnt_uart || gnt_tour) begin
        cmd     <= gnt_uart ? mem[rd_ptr] : tour_cmd;
        owner   <= gnt_tour;
        rr_last <= gnt_tour;
        cmd_rdy <= 1'b1;
      end else if (state == GRANT && clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tmo_cnt;

  // tmo_cnt counts completed EXEC cycles; a send_resp in the final cycle still wins.
  assign tmo_hit     = (state == EXEC) && !send_resp && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_err = tmo_hit && !rst;

  always_ff @(posedge clk) begin
    if (rst || state != EXEC) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_arbiter.sv
// Table-driven bench for cmd_arbiter: one row per cycle (inputs, expected outputs, repeat count).
module tb_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] uart_cmd;
  logic        uart_cmd_rdy;
  logic        uart_clr;
  logic [15:0] tour_cmd;
  logic        tour_cmd_rdy;
  logic        tour_clr;
  logic        tour_lock;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        uart_resp;
  logic        tour_resp;
  logic        owner;
  logic        busy;
  logic        fifo_full;
  logic        timeout_err;

  always #5 clk = ~clk;

  cmd_arbiter #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_cmd     (uart_cmd),
    .uart_cmd_rdy (uart_cmd_rdy),
    .uart_clr     (uart_clr),
    .tour_cmd     (tour_cmd),
    .tour_cmd_rdy (tour_cmd_rdy),
    .tour_clr     (tour_clr),
    .tour_lock    (tour_lock),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .uart_resp    (uart_resp),
    .tour_resp    (tour_resp),
    .owner        (owner),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .timeout_err  (timeout_err)
  );

  // input bits: {rst, uart_cmd_rdy, tour_cmd_rdy, tour_lock, clr_cmd_rdy, send_resp}
  localparam logic [5:0] I_RST  = 6'b100000;
  localparam logic [5:0] I_UART = 6'b010000;
  localparam logic [5:0] I_TOUR = 6'b001000;
  localparam logic [5:0] I_LOCK = 6'b000100;
  localparam logic [5:0] I_CLR  = 6'b000010;
  localparam logic [5:0] I_RESP = 6'b000001;
  // output bits: {uart_clr, tour_clr, cmd_rdy, uart_resp, tour_resp, owner, busy, fifo_full, timeout_err}
  localparam logic [8:0] O_UCLR = 9'b100000000;
  localparam logic [8:0] O_TCLR = 9'b010000000;
  localparam logic [8:0] O_CRDY = 9'b001000000;
  localparam logic [8:0] O_URSP = 9'b000100000;
  localparam logic [8:0] O_TRSP = 9'b000010000;
  localparam logic [8:0] O_OWN  = 9'b000001000;
  localparam logic [8:0] O_BUSY = 9'b000000100;
  localparam logic [8:0] O_FULL = 9'b000000010;
  localparam logic [8:0] O_TERR = 9'b000000001;

  typedef struct {
    string       tag;
    int          n;
    logic [5:0]  in;
    logic [15:0] ucmd;
    logic [15:0] tcmd;
    logic [8:0]  f;
    logic [15:0] c;
  } vec_t;

  vec_t  tbl[$];
  string cur;
  int    total = 0;
  int    bad   = 0;

  task automatic add(input int n, input logic [5:0] in, input logic [15:0] uc, input logic [15:0] tc,
                     input logic [8:0] f, input logic [15:0] c);
    vec_t v;
    v.tag = cur; v.n = n; v.in = in; v.ucmd = uc; v.tcmd = tc; v.f = f; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic fill();
    cur = "t1_uart_single";
    add(1, I_RST,          0,        0, 0,                   16'h0000);
    add(1, I_UART,         16'h2A05, 0, O_UCLR,              16'h0000);
    add(1, I_CLR,          0,        0, 0,                   16'h0000);
    add(1, I_CLR|I_RESP,   0,        0, O_CRDY|O_BUSY,       16'h2A05);
    add(1, I_CLR,          0,        0, O_BUSY,              16'h2A05);
    add(6, 0,              0,        0, O_BUSY,              16'h2A05);
    add(1, I_RESP,         0,        0, O_BUSY,              16'h2A05);
    add(1, 0,              0,        0, O_URSP,              16'h2A05);
    add(1, 0,              0,        0, 0,                   16'h2A05);

    cur = "t2_fifo_full";
    add(1, I_RST,          0,        0, 0,                   16'h2A05);
    add(1, I_RST,          0,        0, 0,                   16'h0000);
    add(1, I_UART,         16'h0001, 0, O_UCLR,              16'h0000);
    add(1, I_UART,         16'h0002, 0, O_UCLR,              16'h0000);
    add(1, I_UART,         16'h0003, 0, O_UCLR|O_CRDY|O_BUSY, 16'h0001);
    add(1, I_UART,         16'h0004, 0, O_UCLR|O_CRDY|O_BUSY, 16'h0001);
    add(1, I_UART,         16'h0005, 0, O_UCLR|O_CRDY|O_BUSY, 16'h0001);
    add(1, I_UART,         16'h0006, 0, O_CRDY|O_BUSY|O_FULL, 16'h0001);
    add(1, I_UART|I_CLR,   16'h0006, 0, O_CRDY|O_BUSY|O_FULL, 16'h0001);
    add(1, I_UART|I_RESP,  16'h0006, 0, O_BUSY|O_FULL,       16'h0001);
    add(1, I_UART,         16'h0006, 0, O_URSP|O_FULL,       16'h0001);
    add(1, I_UART|I_CLR,   16'h0006, 0, O_UCLR|O_CRDY|O_BUSY, 16'h0002);
    add(1, I_RESP,         0,        0, O_BUSY|O_FULL,       16'h0002);
    add(1, 0,              0,        0, O_URSP|O_FULL,       16'h0002);
    for (int k = 3; k <= 6; k++) begin
      add(1, I_CLR,  0, 0, O_CRDY|O_BUSY, 16'(k));
      add(1, I_RESP, 0, 0, O_BUSY,        16'(k));
      add(1, 0,      0, 0, O_URSP,        16'(k));
    end
    add(2, 0,              0,        0, 0,                   16'h0006);

    cur = "t3_tour_lock";
    add(1, I_RST,          0,        0,        0,            16'h0006);
    add(1, I_RST,          0,        0,        0,            16'h0000);
    add(1, I_LOCK|I_UART,  16'h0A01, 0,        O_UCLR,       16'h0000);
    add(2, I_LOCK,         0,        0,        0,            16'h0000);
    add(1, I_LOCK|I_TOUR,  0,        16'h2002, 0,            16'h0000);
    add(1, I_LOCK|I_TOUR|I_CLR, 0,   16'h2002, O_TCLR|O_CRDY|O_OWN|O_BUSY, 16'h2002);
    add(1, I_LOCK|I_RESP,  0,        0,        O_OWN|O_BUSY, 16'h2002);
    add(1, I_LOCK,         0,        0,        O_TRSP|O_OWN, 16'h2002);
    add(2, I_LOCK,         0,        0,        O_OWN,        16'h2002);
    add(1, 0,              0,        0,        O_OWN,        16'h2002);
    add(1, I_CLR,          0,        0,        O_CRDY|O_BUSY, 16'h0A01);
    add(1, I_RESP,         0,        0,        O_BUSY,       16'h0A01);
    add(1, 0,              0,        0,        O_URSP,       16'h0A01);

    cur = "t4_round_robin";
    add(1, I_RST,          0,        0,        0,            16'h0A01);
    add(1, I_RST,          0,        0,        0,            16'h0000);
    add(1, I_UART,         16'h1111, 0,        O_UCLR,       16'h0000);
    add(1, I_UART|I_TOUR,  16'h2222, 16'h7001, O_UCLR,       16'h0000);
    add(1, I_TOUR|I_CLR,   0,        16'h7001, O_CRDY|O_BUSY, 16'h1111);
    add(1, I_TOUR|I_RESP,  0,        16'h7001, O_BUSY,       16'h1111);
    add(1, I_TOUR,         0,        16'h7001, O_URSP,       16'h1111);
    add(1, I_TOUR|I_CLR,   0,        16'h7001, O_TCLR|O_CRDY|O_OWN|O_BUSY, 16'h7001);
    add(1, I_TOUR|I_RESP,  0,        16'h7002, O_OWN|O_BUSY, 16'h7001);
    add(1, I_TOUR,         0,        16'h7002, O_TRSP|O_OWN, 16'h7001);
    add(1, I_TOUR|I_CLR,   0,        16'h7002, O_CRDY|O_BUSY, 16'h2222);
    add(1, I_TOUR|I_RESP,  0,        16'h7002, O_BUSY,       16'h2222);
    add(1, I_TOUR,         0,        16'h7002, O_URSP,       16'h2222);
    add(1, I_TOUR|I_CLR,   0,        16'h7002, O_TCLR|O_CRDY|O_OWN|O_BUSY, 16'h7002);
    add(1, I_RESP,         0,        0,        O_OWN|O_BUSY, 16'h7002);
    add(1, 0,              0,        0,        O_TRSP|O_OWN, 16'h7002);

    cur = "t5_rst_in_exec";
    add(1, I_RST,          0,        0, O_OWN,               16'h7002);
    add(1, I_RST,          0,        0, 0,                   16'h0000);
    add(1, I_UART,         16'h0B01, 0, O_UCLR,              16'h0000);
    add(1, I_UART,         16'h0B02, 0, O_UCLR,              16'h0000);
    add(1, I_UART|I_CLR,   16'h0B03, 0, O_UCLR|O_CRDY|O_BUSY, 16'h0B01);
    add(1, 0,              0,        0, O_BUSY,              16'h0B01);
    add(1, I_RST|I_RESP|I_UART, 16'h0B04, 0, O_BUSY,         16'h0B01);
    add(1, 0,              0,        0, 0,                   16'h0000);
    add(2, 0,              0,        0, 0,                   16'h0000);

    cur = "t6_exec_wait";
    add(1, I_RST,          0,        0, 0,                   16'h0000);
    add(1, I_UART,         16'h0C01, 0, O_UCLR,              16'h0000);
    add(1, 0,              0,        0, 0,                   16'h0000);
    add(1, I_CLR,          0,        0, O_CRDY|O_BUSY,       16'h0C01);
`ifdef ARB_TIMEOUT_EN
    add(15, 0,             0,        0, O_BUSY,              16'h0C01);
    add(1, 0,              0,        0, O_BUSY|O_TERR,       16'h0C01);
    add(1, I_TOUR,         0,        16'h3003, 0,            16'h0C01);
    add(1, I_TOUR|I_CLR,   0,        16'h3003, O_TCLR|O_CRDY|O_OWN|O_BUSY, 16'h3003);
    add(15, 0,             0,        0, O_OWN|O_BUSY,        16'h3003);
    add(1, I_RESP,         0,        0, O_OWN|O_BUSY,        16'h3003);
    add(1, 0,              0,        0, O_TRSP|O_OWN,        16'h3003);
`else
    add(20, 0,             0,        0, O_BUSY,              16'h0C01);
    add(1, I_RESP,         0,        0, O_BUSY,              16'h0C01);
    add(1, 0,              0,        0, O_URSP,              16'h0C01);
`endif
  endtask

  initial begin
    repeat (5000) @(posedge clk);
    bad++;
    $display("FAIL watchdog: bench did not finish within 5000 cycles, total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [8:0] got;
    rst = 1'b1; uart_cmd = '0; uart_cmd_rdy = 1'b0; tour_cmd = '0; tour_cmd_rdy = 1'b0;
    tour_lock = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    fill();
    @(posedge clk); #1;
    got = {uart_clr, tour_clr, cmd_rdy, uart_resp, tour_resp, owner, busy, fifo_full, timeout_err};
    total++;
    if (got !== 9'b0 || cmd !== 16'h0000) begin
      bad++;
      $display("FAIL reset state: flags got %b want %b, cmd got %h want %h", got, 9'b0, cmd, 16'h0000);
    end
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        rst          = tbl[i].in[5];
        uart_cmd_rdy = tbl[i].in[4];
        tour_cmd_rdy = tbl[i].in[3];
        tour_lock    = tbl[i].in[2];
        clr_cmd_rdy  = tbl[i].in[1];
        send_resp    = tbl[i].in[0];
        uart_cmd     = tbl[i].ucmd;
        tour_cmd     = tbl[i].tcmd;
        @(negedge clk);
        got = {uart_clr, tour_clr, cmd_rdy, uart_resp, tour_resp, owner, busy, fifo_full, timeout_err};
        total++;
        if (got !== tbl[i].f || cmd !== tbl[i].c) begin
          bad++;
          $display("FAIL %s row %0d rep %0d: flags got %b want %b, cmd got %h want %h",
                   tbl[i].tag, i, k, got, tbl[i].f, cmd, tbl[i].c);
        end
        @(posedge clk); #1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
